// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state type and skid-buffer depth for the fetch stage.
package fetch_pkg;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;
    localparam int FIFO_DEPTH  = 2;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry shift FIFO of {pc, instr}; entry 0 is the registered head.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               push_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [1:0]         count_o,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o
);
    logic [1:0]         count_q, count_d, base;
    logic [ADDR_W-1:0]  pc_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pc_d [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_q [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_d [FIFO_DEPTH];
    logic               pop;

    assign pop  = pop_i && count_q != 2'd0;
    assign base = count_q - {1'b0, pop};

    // Push lands after the shift so a simultaneous pop+push into one entry keeps the new data.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (pop) begin
            pc_d[0]    = pc_q[1];
            instr_d[0] = instr_q[1];
        end
        if (push_i) begin
            pc_d[base[0]]    = pc_i;
            instr_d[base[0]] = instr_i;
        end
        count_d = flush_i ? 2'd0 : base + {1'b0, push_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 2'd0;
            pc_q    <= '{default: '0};
            instr_q <= '{default: '0};
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = count_q != 2'd0;
    assign pc_o    = pc_q[0];
    assign instr_o = instr_q[0];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: walks a PC through the synchronous ROM and hands {pc, instr} to decode.
// Define FETCH_BOUNDS_CHECK_EN to stop fetch past i_max_addr (DRAIN/HALT); otherwise PC wraps forever.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load_done,
    input  logic [ADDR_W-1:0]  i_max_addr,
    output logic [ADDR_W-1:0]  o_addr_read,
    input  logic [INSTR_W-1:0] i_instr_read,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    output logic               o_halted
);
    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q, tag_q;
    logic              inflight_q;
    logic [1:0]        count;
    logic              active, reload, redirect, pop, oob, credit, issue;

    assign active   = state_q != IDLE;
    assign reload   = active && !i_load_done;
    assign redirect = active && i_load_done && i_redirect;
    assign pop      = o_valid && i_ready;
    // Occupancy plus the read in flight may never exceed the two buffer entries.
    assign credit   = ({1'b0, count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});

`ifdef FETCH_BOUNDS_CHECK_EN
    assign oob      = pc_q > i_max_addr;
    assign o_halted = state_q == HALT;
`else
    logic unused_max;
    assign unused_max = ^i_max_addr;
    assign oob        = 1'b0;
    assign o_halted   = 1'b0;
`endif

    assign issue       = state_q == FETCH && !reload && !redirect && !oob && credit;
    assign o_addr_read = pc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_q <= pc_q;
                pc_q  <= pc_q + ADDR_W'(1);
            end
            if (reload) begin
                state_q <= IDLE;
                pc_q    <= RESET_PC;
            end else if (redirect) begin
                state_q <= FETCH;
                pc_q    <= i_redirect_addr;
            end else begin
                case (state_q)
                    IDLE: if (i_load_done) begin
                        state_q <= FETCH;
                        pc_q    <= RESET_PC;
                    end
                    FETCH: if (oob) state_q <= DRAIN;
                    DRAIN: if (count == 2'd0 && !inflight_q) state_q <= HALT;
                    default: ;
                endcase
            end
        end
    end

    // A return arriving alongside a flush is dropped inside the buffer.
    fetch_skid_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_buf (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .push_i  (inflight_q),
        .pc_i    (tag_q),
        .instr_i (i_instr_read),
        .pop_i   (pop),
        .flush_i (reload || redirect),
        .count_o (count),
        .valid_o (o_valid),
        .pc_o    (o_pc),
        .instr_o (o_instr)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the fetch stage against a ROM holding 0x1000+addr.
module tb_instr_fetch_unit;
    localparam int AW = 8;
    localparam int IW = 16;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam int LAST = 5;
`else
    localparam int LAST = 9;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_done = 1'b0;
    logic          ready = 1'b0;
    logic          redir = 1'b0;
    logic [AW-1:0] max_addr = 8'd5;
    logic [AW-1:0] redir_addr = '0;
    logic [AW-1:0] addr_read, pc_out;
    logic [IW-1:0] rom_data, instr_out;
    logic          valid, halted;
    int            total = 0;
    int            bad = 0;
    logic [AW-1:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= 16'h1000 + 16'(addr_read);

    instr_fetch_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_load_done     (load_done),
        .i_max_addr      (max_addr),
        .o_addr_read     (addr_read),
        .i_instr_read    (rom_data),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_instr         (instr_out),
        .o_pc            (pc_out),
        .i_redirect      (redir),
        .i_redirect_addr (redir_addr),
        .o_halted        (halted)
    );

    task automatic monitor();
        logic          stall = 1'b0;
        logic [AW-1:0] spc = '0;
        logic [IW-1:0] sins = '0;
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && stall) begin
                total++;
                if (valid !== 1'b1 || pc_out !== spc || instr_out !== sins) begin
                    bad++;
                    $display("FAIL hold: valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", valid, pc_out, instr_out, spc, sins);
                end
            end
            stall = rst_n && load_done && !redir && valid === 1'b1 && !ready;
            spc   = pc_out;
            sins  = instr_out;
            if (rst_n && valid === 1'b1 && ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_pop: pc=%h instr=%h want nothing", pc_out, instr_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e || instr_out !== 16'h1000 + 16'(e)) begin
                        bad++;
                        $display("FAIL pop: pc=%h instr=%h want pc=%h instr=%h", pc_out, instr_out, e, 16'h1000 + 16'(e));
                    end
                end
            end
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        load_done = 1'b0;
        redir = 1'b0;
        ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 load_done = 1'b1;
    endtask

    task automatic drain(input int pattern, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
            ready = pattern == 0 ? 1'b1 : (cycles % 3 == 1);
        end
        ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 5;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (pc_out !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc_out); end
        if (instr_out !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instr_out); end
        if (addr_read !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", addr_read); end
        if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_stream();
        int c;
        restart();
        ready = 1'b1;
        for (int i = 0; i <= LAST; i++) exp_q.push_back(AW'(i));
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (valid !== (k == 3)) begin
                bad++;
                $display("FAIL latency: cycle %0d valid=%b want %b", k, valid, k == 3);
            end
        end
        drain(0, c);
        total++;
        if (c != LAST + 1) begin bad++; $display("FAIL throughput: cycles=%0d want %0d", c, LAST + 1); end
`ifdef FETCH_BOUNDS_CHECK_EN
        for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        total += 2;
        if (halted !== 1'b1) begin bad++; $display("FAIL halt: halted=%b want 1", halted); end
        if (valid !== 1'b0) begin bad++; $display("FAIL halt_valid: valid=%b want 0", valid); end
`endif
    endtask

`ifdef FETCH_BOUNDS_CHECK_EN
    task automatic test_halt_redirect();
        int c;
        redir = 1'b1;
        redir_addr = 8'h02;
        @(posedge clk);
        #1 redir = 1'b0;
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL unhalt: halted=%b want 0", halted); end
        for (int i = 2; i <= 5; i++) exp_q.push_back(AW'(i));
        drain(0, c);
        for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (halted !== 1'b1) begin bad++; $display("FAIL rehalt: halted=%b want 1", halted); end
    endtask
`endif

    task automatic test_backpressure();
        int c;
        restart();
        for (int i = 0; i <= LAST; i++) exp_q.push_back(AW'(i));
        drain(1, c);
    endtask

    task automatic test_redirect();
        logic done = 1'b0;
        restart();
        ready = 1'b1;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        for (int i = 3; i <= LAST; i++) exp_q.push_back(AW'(i));
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
            if (redir) begin
                redir = 1'b0;
                total += 2;
                if (valid !== 1'b0) begin bad++; $display("FAIL redirect_flush: valid=%b want 0", valid); end
                if (addr_read !== 8'd3) begin bad++; $display("FAIL redirect_addr: got %h want 03", addr_read); end
            end else if (!done && valid === 1'b1 && pc_out == 8'd1) begin
                redir = 1'b1;
                redir_addr = 8'd3;
                done = 1'b1;
            end
        end
        ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || !done) begin
            bad++;
            $display("FAIL redirect_done: left=%0d fired=%b want 0 and 1", exp_q.size(), done);
            exp_q.delete();
        end
    endtask

    task automatic test_reload();
        int c;
        restart();
        repeat (6) @(posedge clk);
        #1;
        total += 2;
        if (valid !== 1'b1) begin bad++; $display("FAIL reload_full: valid=%b want 1", valid); end
        if (pc_out !== 8'd0) begin bad++; $display("FAIL reload_head: pc=%h want 00", pc_out); end
        load_done = 1'b0;
        @(posedge clk);
        #1;
        total += 2;
        if (valid !== 1'b0) begin bad++; $display("FAIL reload_flush: valid=%b want 0", valid); end
        if (addr_read !== 8'd0) begin bad++; $display("FAIL reload_pc: got %h want 00", addr_read); end
        load_done = 1'b1;
        ready = 1'b1;
        for (int i = 0; i <= 3; i++) exp_q.push_back(AW'(i));
        drain(0, c);
    endtask

    task automatic test_reset_mid();
        int c;
        restart();
        ready = 1'b1;
        for (int i = 0; i <= LAST; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < 20 && !(valid === 1'b1 && pc_out == 8'd2); i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", valid); end
        if (pc_out !== 8'h00) begin bad++; $display("FAIL mid_pc: got %h want 00", pc_out); end
        if (instr_out !== 16'h0000) begin bad++; $display("FAIL mid_instr: got %h want 0000", instr_out); end
        if (addr_read !== 8'h00) begin bad++; $display("FAIL mid_addr: got %h want 00", addr_read); end
        exp_q.delete();
        load_done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 load_done = 1'b1;
        for (int i = 0; i <= 3; i++) exp_q.push_back(AW'(i));
        drain(0, c);
    endtask

`ifndef FETCH_BOUNDS_CHECK_EN
    task automatic test_wrap();
        int c;
        restart();
        ready = 1'b1;
        for (int i = 0; i < 260; i++) exp_q.push_back(AW'(i));
        drain(0, c);
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL wrap_halted: got %b want 0", halted); end
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_stream();
`ifdef FETCH_BOUNDS_CHECK_EN
        test_halt_redirect();
`endif
        test_backpressure();
        test_redirect();
        test_reload();
        test_reset_mid();
`ifndef FETCH_BOUNDS_CHECK_EN
        test_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the instruction ROM.
- Waits for the ROM's load-done flag, then walks a PC through the ROM read port.
- Absorbs the ROM's 1-cycle synchronous read latency and presents {pc, instr} to decode over a valid/ready handshake.
- Supports decode/execute-initiated redirects (branch/jump).
- Stops at the last loaded address.

Parameters:
ADDR_W, 8, ROM address / PC width
INSTR_W, 16, instruction width
RESET_PC, 0, PC loaded at reset and on every load-done rising edge

Ports:
i_clk  in  1  CPU clock (50 MHz); the only clock
i_rst_n  in  1  reset; asynchronous assert, active-low
i_load_done  in  1  ROM image loaded and transmit complete (level)
i_max_addr  in  ADDR_W  address of last valid instruction in ROM
o_addr_read  out  ADDR_W  ROM read address
i_instr_read  in  INSTR_W  ROM read data, valid 1 cycle after address
o_valid  out  1  o_instr/o_pc hold a fetched instruction
i_ready  in  1  decode accepts this cycle
o_instr  out  INSTR_W  fetched instruction
o_pc  out  ADDR_W  address of o_instr
i_redirect  in  1  flush and restart fetch at i_redirect_addr
i_redirect_addr  in  ADDR_W  redirect target
o_halted  out  1  fetch stopped past i_max_addr

Behaviour:
Reset, asynchronous on i_rst_n low: state=IDLE, pc=RESET_PC, buffer empty, inflight=0, o_valid=0, o_instr=0, o_pc=0, o_halted=0, o_addr_read=RESET_PC.

FSM states: IDLE, FETCH, DRAIN, HALT.
- IDLE: no issue. Moves to FETCH on the edge where i_load_done=1; pc=RESET_PC.
- FETCH: issues one read per cycle while credit allows.
  - Credit rule: issue iff (count + inflight - pop) < 2, with pop = o_valid & i_ready.
  - o_addr_read = pc at all times. An issue sets inflight for the next cycle and increments pc, wrapping mod 2^ADDR_W.
- Return path: in the cycle after an issue, i_instr_read is pushed into the 2-entry FIFO tagged with the issued pc, unless discarded.
  - o_valid/o_instr/o_pc come from the FIFO head, registered.
  - Issue-to-o_valid latency: 2 cycles.
  - Sustained throughput is 1 instruction per cycle with i_ready held high.
- Handshake:
  - o_instr and o_pc stay stable while o_valid=1 and i_ready=0.
  - The FIFO never overflows; the credit rule guarantees this.
- Redirect (any state except IDLE):
  - Flushes the FIFO, sets o_valid=0 the next cycle, and marks any inflight return as discarded.
  - pc is set to i_redirect_addr; fetch restarts the next cycle.
  - A redirect from DRAIN or HALT returns to FETCH and clears o_halted.
  - Redirect plus pop in the same cycle: the pop counts as consumed; the flush applies to the remainder.
  - Redirect plus data return in the same cycle: the data is dropped.
- Bounds: when an issue would use pc > i_max_addr, it is suppressed and state goes to DRAIN. DRAIN goes to HALT once the FIFO is empty and inflight=0. HALT sets o_halted=1.
- i_load_done falling (reload): return to IDLE next cycle, flush, o_halted=0. This has priority over redirect.
- Empty ROM corner: i_max_addr < RESET_PC goes straight to DRAIN, then HALT, with no o_valid ever asserted.

Optional Feature:
FETCH_BOUNDS_CHECK_EN
- Defined: DRAIN/HALT behaviour as specified above.
- Undefined: no comparison against i_max_addr; pc wraps 255→0 indefinitely; o_halted is tied to 0; DRAIN and HALT are unreachable.

Decomposition:
Package fetch_pkg holds:
- ADDR_W and INSTR_W defaults
- fetch_state_t enum {IDLE, FETCH, DRAIN, HALT}
- FIFO_DEPTH=2

Sub-module fetch_skid_buffer: 2-entry FIFO of {pc, instr} with push/pop/flush, count output and registered head. It is instantiated once.

Test Plan:
- ROM holds 0x1000+i at addr i, max_addr=5, i_ready=1, raise i_load_done → o_valid first high 3 cycles after load_done edge; o_pc 0..5 back-to-back with o_instr 0x1000..0x1005; then o_halted=1, o_valid=0.
- Same image, i_ready toggling 1,0,0,1,… → every pc 0..5 delivered exactly once, in order; o_instr stable while stalled; no loss.
- During streaming, i_redirect=1 with addr=3 in the cycle o_pc=1 is popped → pc 2 never appears; next o_pc sequence is 3,4,5.
- In HALT, redirect to 0x02 → o_halted clears next cycle; o_pc 2..5 delivered again; re-halts.
- Assert i_rst_n=0 mid-stream, off-edge → outputs zero immediately; after release and load_done, fetch restarts at 0.
- FETCH_BOUNDS_CHECK_EN undefined, max_addr=5 → fetch runs past 5 to 255, wraps to 0; o_halted never set.
